// File: rtl/convolution_feeder.sv
// Sequencer feeding kernel weights then one row-major image frame into a KxK convolution engine.
// Optional macro CONV_FEEDER_KEEP_KERNEL_EN adds keep_kernel to skip the kernel load.
module convolution_feeder #(
  parameter int MAX_XRES    = 128,
  parameter int XRES1       = 16,
  parameter int XRES2       = 32,
  parameter int XRES3       = 64,
  parameter int XRES4       = 4,
  parameter int XRES5       = 8,
  parameter int RESOLUTIONS = 5,
  parameter int MAX_YRES    = 128,
  parameter int K           = 3,
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = $clog2(MAX_XRES*MAX_YRES)
) (
  input  logic                          clock,
  input  logic                          clock_sreset,
  input  logic                          start,
  input  logic [2:0]                    xres_select,
  input  logic [$clog2(MAX_YRES+1)-1:0] yres,
  input  logic [ADDR_W-1:0]             img_base,
  input  logic                          stall,
`ifdef CONV_FEEDER_KEEP_KERNEL_EN
  input  logic                          keep_kernel,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(K*K)-1:0]        kernel_rd_addr,
  input  logic [WIDTH-1:0]              kernel_rd_data,
  output logic [ADDR_W-1:0]             img_rd_addr,
  input  logic [WIDTH-1:0]              img_rd_data,
  output logic                          kernel_data_shift,
  output logic [WIDTH-1:0]              kernel_data,
  output logic                          data_shift,
  output logic [WIDTH-1:0]              data,
  output logic                          enable_calc
);

  localparam int XW  = $clog2(MAX_XRES+1);
  localparam int YW  = $clog2(MAX_YRES+1);
  localparam int KAW = $clog2(K*K);
  localparam logic [KAW-1:0] K_LAST = KAW'(K*K-1);
  localparam logic [XW-1:0]  KM1_X  = XW'(K-1);
  localparam logic [YW-1:0]  KM1_Y  = YW'(K-1);

  typedef enum logic [1:0] {IDLE, KLOAD, STREAM, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_last_q, x_last_d;
  logic [YW-1:0]     y_last_q, y_last_d;
  logic [XW-1:0]     col_q, col_d;
  logic [YW-1:0]     row_q, row_d;
  logic [KAW-1:0]    kidx_q, kidx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              kshift_q, kshift_d;
  logic              pshift_q, pshift_d;
  logic              win_q, win_d;
  logic              en_q, en_d;
  logic              done_q, done_d;

  logic [XW-1:0]     x_sel;
  logic              xsel_ok;
  logic              accept;
  logic              keep;
  logic              last_pix;

`ifdef CONV_FEEDER_KEEP_KERNEL_EN
  assign keep = keep_kernel;
`else
  assign keep = 1'b0;
`endif

  always_comb begin
    x_sel = XW'(XRES1);
    case (xres_select)
      3'd0:    x_sel = XW'(XRES1);
      3'd1:    x_sel = XW'(XRES2);
      3'd2:    x_sel = XW'(XRES3);
      3'd3:    x_sel = XW'(XRES4);
      3'd4:    x_sel = XW'(XRES5);
      default: x_sel = XW'(XRES1);
    endcase
  end

  assign xsel_ok  = int'(xres_select) < RESOLUTIONS;
  assign accept   = start && xsel_ok && (yres >= YW'(K)) && (yres <= YW'(MAX_YRES));
  assign last_pix = (col_q == x_last_q) && (row_q == y_last_q);

  always_ff @(posedge clock or negedge clock_sreset) begin
    if (!clock_sreset) begin
      state_q  <= IDLE;
      x_last_q <= '0;
      y_last_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      kidx_q   <= '0;
      addr_q   <= '0;
      kshift_q <= 1'b0;
      pshift_q <= 1'b0;
      win_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
      col_q    <= col_d;
      row_q    <= row_d;
      kidx_q   <= kidx_d;
      addr_q   <= addr_d;
      kshift_q <= kshift_d;
      pshift_q <= pshift_d;
      win_q    <= win_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = keep ? STREAM : KLOAD;
      KLOAD:   if (!stall && kidx_q == K_LAST) state_d = STREAM;
      STREAM:  if (!stall && last_pix) state_d = DRAIN;
      DRAIN:   if (!pshift_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window flag travels with the pixel read so enable_calc follows shifts, not cycles.
  always_comb begin
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    col_d    = col_q;
    row_d    = row_q;
    kidx_d   = kidx_q;
    addr_d   = addr_q;
    kshift_d = 1'b0;
    pshift_d = 1'b0;
    win_d    = 1'b0;
    en_d     = pshift_q && win_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x_last_d = x_sel - XW'(1);
          y_last_d = yres - YW'(1);
          addr_d   = img_base;
          col_d    = '0;
          row_d    = '0;
          kidx_d   = '0;
        end
      end
      KLOAD: begin
        if (!stall) begin
          kshift_d = 1'b1;
          kidx_d   = (kidx_q == K_LAST) ? '0 : kidx_q + KAW'(1);
        end
      end
      STREAM: begin
        if (!stall) begin
          pshift_d = 1'b1;
          win_d    = (row_q >= KM1_Y) && (col_q >= KM1_X);
          addr_d   = addr_q + ADDR_W'(1);
          if (col_q == x_last_q) begin
            col_d = '0;
            row_d = row_q + YW'(1);
          end else begin
            col_d = col_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (!pshift_q) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy              = (state_q != IDLE);
    done              = done_q;
    kernel_rd_addr    = kidx_q;
    img_rd_addr       = addr_q;
    kernel_data_shift = kshift_q;
    kernel_data       = kshift_q ? kernel_rd_data : '0;
    data_shift        = pshift_q;
    data              = pshift_q ? img_rd_data : '0;
    enable_calc       = en_q;
  end

endmodule

// File: tb/tb_convolution_feeder.sv
// Scoreboard bench for convolution_feeder: frames are modelled as lists of expected
// kernel words, pixels with window flags, and per-frame enable counts.
module tb_convolution_feeder;
  localparam int K        = 3;
  localparam int WIDTH    = 16;
  localparam int MAX_XRES = 128;
  localparam int MAX_YRES = 128;
  localparam int ADDR_W   = $clog2(MAX_XRES*MAX_YRES);
  localparam int YW       = $clog2(MAX_YRES+1);
  localparam int KAW      = $clog2(K*K);
  localparam int NPIX     = 1 << ADDR_W;

  logic              clock, clock_sreset, start, stall;
  logic [2:0]        xres_select;
  logic [YW-1:0]     yres;
  logic [ADDR_W-1:0] img_base;
  logic              busy, done;
  logic [KAW-1:0]    kernel_rd_addr;
  logic [WIDTH-1:0]  kernel_rd_data;
  logic [ADDR_W-1:0] img_rd_addr;
  logic [WIDTH-1:0]  img_rd_data;
  logic              kernel_data_shift, data_shift, enable_calc;
  logic [WIDTH-1:0]  kernel_data, data;
`ifdef CONV_FEEDER_KEEP_KERNEL_EN
  logic              keep_kernel;
`endif

  convolution_feeder #(.MAX_XRES(MAX_XRES), .MAX_YRES(MAX_YRES), .K(K), .WIDTH(WIDTH)) dut (
    .clock(clock), .clock_sreset(clock_sreset), .start(start),
    .xres_select(xres_select), .yres(yres), .img_base(img_base), .stall(stall),
`ifdef CONV_FEEDER_KEEP_KERNEL_EN
    .keep_kernel(keep_kernel),
`endif
    .busy(busy), .done(done),
    .kernel_rd_addr(kernel_rd_addr), .kernel_rd_data(kernel_rd_data),
    .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .kernel_data_shift(kernel_data_shift), .kernel_data(kernel_data),
    .data_shift(data_shift), .data(data), .enable_calc(enable_calc)
  );

  typedef struct { logic [WIDTH-1:0] d; bit win; } pix_t;

  int               xres_tab[5] = '{16, 32, 64, 4, 8};
  logic [WIDTH-1:0] kmem [K*K];
  logic [WIDTH-1:0] img  [NPIX];
  logic [WIDTH-1:0] kq[$];
  pix_t             pq[$];
  int               fq[$];
  int               errors = 0, checks = 0;
  int               done_cnt = 0, pix_cnt = 0;
  int               stall_mode = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    kernel_rd_data <= kmem[kernel_rd_addr];
    img_rd_data    <= img[img_rd_addr];
  end

  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (stall_mode)
        0:       stall = 1'b0;
        1:       stall = ~stall;
        default: stall = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Monitor: consumes expectations whenever the DUT presents a shift, enable or done.
  initial begin
    bit               prev_win, next_win;
    int               en_cnt, ef;
    logic [WIDTH-1:0] ke;
    pix_t             p;
    prev_win = 1'b0;
    en_cnt   = 0;
    forever begin
      @(negedge clock);
      if (!clock_sreset) begin
        prev_win = 1'b0;
        en_cnt   = 0;
      end else begin
        next_win = 1'b0;
        if (kernel_data_shift && data_shift) begin
          checks++; errors++;
          $display("FAIL shift_overlap: kernel_data_shift and data_shift both 1, required exclusive");
        end
        if (kernel_data_shift) begin
          checks++;
          if (kq.size() == 0) begin
            errors++; $display("FAIL kernel_extra: got word %0h, required no kernel shift", kernel_data);
          end else begin
            ke = kq.pop_front();
            if (kernel_data !== ke) begin
              errors++; $display("FAIL kernel_data: got %0h, required %0h", kernel_data, ke);
            end
          end
        end
        if (data_shift) begin
          pix_cnt++;
          checks++;
          if (pq.size() == 0) begin
            errors++; $display("FAIL pixel_extra: got %0h, required no data shift", data);
          end else begin
            p = pq.pop_front();
            next_win = p.win;
            if (data !== p.d) begin
              errors++; $display("FAIL pixel_data: got %0h, required %0h", data, p.d);
            end
          end
        end
        if (enable_calc || prev_win) begin
          checks++;
          if (enable_calc !== prev_win) begin
            errors++; $display("FAIL enable_calc: got %0b, required %0b", enable_calc, prev_win);
          end
        end
        if (enable_calc) en_cnt++;
        prev_win = next_win;
        if (done) begin
          checks++;
          done_cnt++;
          if (fq.size() == 0) begin
            errors++; $display("FAIL done_extra: got done=1, required 0");
          end else begin
            ef = fq.pop_front();
            if (en_cnt != ef || kq.size() != 0 || pq.size() != 0 || busy !== 1'b0) begin
              errors++;
              $display("FAIL done_frame: got enables=%0d kleft=%0d pleft=%0d busy=%0b, required %0d/0/0/0",
                       en_cnt, kq.size(), pq.size(), busy, ef);
            end
          end
          en_cnt = 0;
        end
      end
    end
  end

  task automatic expect_frame(input int xsel, input int yr, input int base, input bit keep);
    int   x;
    pix_t p;
    x = xres_tab[xsel];
    if (!keep)
      for (int i = 0; i < K*K; i++) kq.push_back(kmem[i]);
    for (int r = 0; r < yr; r++)
      for (int c = 0; c < x; c++) begin
        p.d   = img[(base + r*x + c) % NPIX];
        p.win = (r >= K-1) && (c >= K-1);
        pq.push_back(p);
      end
    fq.push_back((x - K + 1) * (yr - K + 1));
  endtask

  task automatic do_start(input int xsel, input int yr, input int base, input bit keep, input bit now);
    bit acc, k;
    if (!now) @(posedge clock);
    #1;
    k = 1'b0;
`ifdef CONV_FEEDER_KEEP_KERNEL_EN
    keep_kernel = keep;
    k = keep;
`endif
    start       = 1'b1;
    xres_select = xsel[2:0];
    yres        = yr[YW-1:0];
    img_base    = base[ADDR_W-1:0];
    @(posedge clock);
    acc = (fq.size() == 0) && (xsel < 5) && (yr >= K) && (yr <= MAX_YRES);
    if (acc) expect_frame(xsel, yr, base, k);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== (fq.size() != 0)) begin
      errors++; $display("FAIL busy_after_start: got %0b, required %0b", busy, fq.size() != 0);
    end
    if (acc && !k) begin
      checks++;
      if (kernel_rd_addr !== '0) begin
        errors++; $display("FAIL kaddr_first: got %0d, required 0", kernel_rd_addr);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    clock_sreset = 1'b0;
    #1;
    checks++;
    if ({busy, done, kernel_data_shift, data_shift, enable_calc} !== 5'b0 ||
        kernel_rd_addr !== '0 || img_rd_addr !== '0 || kernel_data !== '0 || data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b ks=%0b ds=%0b en=%0b ka=%0d ia=%0d, required all 0",
               busy, done, kernel_data_shift, data_shift, enable_calc, kernel_rd_addr, img_rd_addr);
    end
    kq.delete(); pq.delete(); fq.delete();
    repeat (2) @(posedge clock);
    #3;
    clock_sreset = 1'b1;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = done_cnt;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clock);
      if (done_cnt > n) return;
    end
    checks++; errors++;
    $display("FAIL done_timeout: got no done in %0d cycles, required one", max_cycles);
    do_reset();
  endtask

  initial begin
    int p0, xs, yr, base;
    bit kp;
    start = 1'b0; xres_select = '0; yres = '0; img_base = '0;
`ifdef CONV_FEEDER_KEEP_KERNEL_EN
    keep_kernel = 1'b0;
`endif
    for (int i = 0; i < K*K; i++) kmem[i] = WIDTH'(i + 1);
    for (int i = 0; i < NPIX; i++) img[i] = WIDTH'($urandom);

    clock_sreset = 1'b1;
    #1 clock_sreset = 1'b0;
    #1;
    checks++;
    if ({busy, done, kernel_data_shift, data_shift, enable_calc} !== 5'b0 || img_rd_addr !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%0b done=%0b ia=%0d, required 0", busy, done, img_rd_addr);
    end
    repeat (2) @(posedge clock);
    #3 clock_sreset = 1'b1;

    // Basic 4x4 frame, then the same with alternating stall.
    do_start(3, 4, 0, 1'b0, 1'b0);
    wait_done(300);
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_idle: got %0b, required 0", busy);
    end
    stall_mode = 1;
    do_start(3, 4, 0, 1'b0, 1'b0);
    wait_done(600);
    stall_mode = 0;

    // Illegal starts are ignored.
    do_start(5, 4, 0, 1'b0, 1'b0);
    do_start(3, 2, 0, 1'b0, 1'b0);
    do_start(0, 200, 0, 1'b0, 1'b0);
    repeat (10) @(posedge clock);

    // Reset after seven pixels, then a clean rerun.
    do_start(3, 4, 0, 1'b0, 1'b0);
    p0 = pix_cnt;
    for (int i = 0; i < 100 && pix_cnt - p0 < 7; i++) @(posedge clock);
    do_reset();
    repeat (5) @(posedge clock);
    do_start(3, 4, 0, 1'b0, 1'b0);
    wait_done(300);

    // Start while busy is dropped; start right after done is taken.
    do_start(1, 4, 100, 1'b0, 1'b0);
    repeat (20) @(posedge clock);
    do_start(0, 5, 0, 1'b0, 1'b0);
    for (int i = 0; i < K*K; i++) kmem[i] = WIDTH'($urandom);
    wait_done(1000);
    do_start(4, 3, 50, 1'b0, 1'b1);
    wait_done(300);

    // Randomised frames, some with the address wrapping past the top of RAM.
    stall_mode = 2;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < K*K; i++) kmem[i] = WIDTH'($urandom);
      xs   = $urandom_range(0, 4);
      yr   = $urandom_range(K, 6);
      base = (t % 3 == 0) ? NPIX - $urandom_range(1, 20) : $urandom_range(0, NPIX - 1);
      kp   = 1'b0;
`ifdef CONV_FEEDER_KEEP_KERNEL_EN
      kp   = $urandom_range(0, 1) == 1;
`endif
      do_start(xs, yr, base, kp, 1'b0);
      wait_done(4000);
    end
    stall_mode = 0;

`ifdef CONV_FEEDER_KEEP_KERNEL_EN
    do_start(4, 3, 7, 1'b1, 1'b0);
    wait_done(300);
`endif

    repeat (5) @(posedge clock);
    checks++;
    if (kq.size() != 0 || pq.size() != 0 || fq.size() != 0) begin
      errors++; $display("FAIL leftover: got k=%0d p=%0d f=%0d pending, required 0", kq.size(), pq.size(), fq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
